verificador_de_senha: RTL and testbench

VERIFICADOR_DE_SENHA -- requirements
Module: verificador_de_senha

---
 rtl/verificador_de_senha.sv | 189 ++++++++++++++++++
 tb/tb_verificador_de_senha.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_de_senha.sv
// Keypad password checker: verifies user attempts against a stored password,
// locks out after repeated failures and lets the master password reprogram it.
package verificador_de_senha_pkg;
   typedef logic [19:0][3:0] senhaPac_t;
endpackage

module verificador_de_senha
   import verificador_de_senha_pkg::*;
#(
   parameter int        MAX_TENTATIVAS = 3,
   parameter int        T_BLOQUEIO     = 10000,
   parameter int        T_PROG         = 5000,
   parameter senhaPac_t SENHA_PADRAO   = 80'h4321_FFFF_FFFF_FFFF_FFFF
)(
   input  logic       clk,
   input  logic       rst,
   input  senhaPac_t  digitos_value,
   input  logic       digitos_valid,
   input  senhaPac_t  senha_mestra,
   output logic       senha_ok,
   output logic       senha_erro,
   output logic       prog_ok,
   output logic       modo_prog,
   output logic       bloqueado,
   output logic [1:0] falhas
);
   localparam int FW = $clog2(MAX_TENTATIVAS) + 1;
   localparam int BW = $clog2(T_BLOQUEIO) + 1;
   localparam int PW = $clog2(T_PROG) + 1;
   localparam logic [FW-1:0] FALHAS_MAX = FW'(MAX_TENTATIVAS);
   localparam logic [FW-1:0] FALHAS_LIM = FW'(MAX_TENTATIVAS - 1);
   localparam logic [BW-1:0] BLOQ_FIM   = BW'(T_BLOQUEIO - 1);
   localparam logic [PW-1:0] PROG_FIM   = PW'(T_PROG - 1);

   typedef enum logic [2:0] {OCIOSO, VERIFICAR, PROGRAMAR, GRAVAR, BLOQUEADO} estado_t;

   // Per-nibble classification of the incoming packet
   logic [19:0] eh_f;
   logic [19:0] viola;
   for (genvar gi = 0; gi < 20; gi++) begin : g_nibble
      assign eh_f[gi] = (digitos_value[gi] == 4'hF);
      if (gi < 19) begin : g_meio
         // a digit below an F breaks contiguity from the most recent key
         assign viola[gi] = (!eh_f[gi] && digitos_value[gi] > 4'd9) || (eh_f[gi+1] && !eh_f[gi]);
      end else begin : g_topo
         assign viola[gi] = !eh_f[gi] && digitos_value[gi] > 4'd9;
      end
   end

   logic [4:0] n_dig;
   logic       bem_formado, eh_b, eh_e, igual_mestra, igual_usuario;
   assign n_dig         = 5'(20 - $countones(eh_f));
   assign bem_formado   = (viola == '0) && (n_dig >= 5'd4) && (n_dig <= 5'd12);
   assign eh_b          = (digitos_value == {20{4'hB}});
   assign eh_e          = (digitos_value == {20{4'hE}});
   assign igual_mestra  = (digitos_value == senha_mestra);

   estado_t          estado_reg;
   senhaPac_t        senha_reg, pkt_reg;
   logic             mestra_ok_reg, usuario_ok_reg, espera_reg, pend_erro_reg, sair_reg;
   logic [FW-1:0]    falhas_reg;
   logic [BW-1:0]    bloq_cnt_reg;
   logic [PW-1:0]    prog_cnt_reg;
   logic             senha_ok_reg, senha_erro_reg, prog_ok_reg, modo_prog_reg, bloqueado_reg;

   assign igual_usuario = (digitos_value == senha_reg);

   // Captures flag comparisons on the valid edge; espera_reg adds the second
   // cycle so every result pulse lands two edges after the capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_reg     <= OCIOSO;
         senha_reg      <= SENHA_PADRAO;
         pkt_reg        <= '0;
         mestra_ok_reg  <= 1'b0;
         usuario_ok_reg <= 1'b0;
         espera_reg     <= 1'b0;
         pend_erro_reg  <= 1'b0;
         sair_reg       <= 1'b0;
         falhas_reg     <= '0;
         bloq_cnt_reg   <= '0;
         prog_cnt_reg   <= '0;
         senha_ok_reg   <= 1'b0;
         senha_erro_reg <= 1'b0;
         prog_ok_reg    <= 1'b0;
         modo_prog_reg  <= 1'b0;
         bloqueado_reg  <= 1'b0;
      end else begin
         senha_ok_reg   <= 1'b0;
         senha_erro_reg <= 1'b0;
         prog_ok_reg    <= 1'b0;
         case (estado_reg)
            OCIOSO: begin
               if (digitos_valid && !eh_b && !eh_e) begin
                  mestra_ok_reg  <= igual_mestra && bem_formado;
                  usuario_ok_reg <= igual_usuario;
                  espera_reg     <= 1'b1;
                  estado_reg     <= VERIFICAR;
               end
            end
            VERIFICAR: begin
               if (espera_reg) begin
                  espera_reg <= 1'b0;
               end else if (mestra_ok_reg) begin
                  estado_reg    <= PROGRAMAR;
                  modo_prog_reg <= 1'b1;
                  falhas_reg    <= '0;
                  prog_cnt_reg  <= '0;
               end else if (usuario_ok_reg) begin
                  senha_ok_reg <= 1'b1;
                  falhas_reg   <= '0;
                  estado_reg   <= OCIOSO;
               end else begin
                  senha_erro_reg <= 1'b1;
                  if (falhas_reg >= FALHAS_LIM) begin
                     falhas_reg    <= FALHAS_MAX;
                     bloqueado_reg <= 1'b1;
                     bloq_cnt_reg  <= BLOQ_FIM;
                     estado_reg    <= BLOQUEADO;
                  end else begin
                     falhas_reg <= falhas_reg + 1'b1;
                     estado_reg <= OCIOSO;
                  end
               end
            end
            PROGRAMAR: begin
               if (digitos_valid && !pend_erro_reg) begin
                  prog_cnt_reg <= '0;
                  espera_reg   <= 1'b1;
                  if (eh_b || eh_e) begin
                     pend_erro_reg <= 1'b1;
                     sair_reg      <= 1'b1;
                  end else if (bem_formado && !igual_mestra) begin
                     pkt_reg    <= digitos_value;
                     estado_reg <= GRAVAR;
                  end else begin
                     pend_erro_reg <= 1'b1;
                     sair_reg      <= 1'b0;
                  end
               end else if (pend_erro_reg) begin
                  if (espera_reg) begin
                     espera_reg <= 1'b0;
                  end else begin
                     senha_erro_reg <= 1'b1;
                     pend_erro_reg  <= 1'b0;
                     prog_cnt_reg   <= '0;
                     if (sair_reg) begin
                        estado_reg    <= OCIOSO;
                        modo_prog_reg <= 1'b0;
                     end
                  end
               end else if (prog_cnt_reg == PROG_FIM) begin
                  estado_reg    <= OCIOSO;
                  modo_prog_reg <= 1'b0;
               end else begin
                  prog_cnt_reg <= prog_cnt_reg + 1'b1;
               end
            end
            GRAVAR: begin
               if (espera_reg) begin
                  espera_reg <= 1'b0;
               end else begin
                  senha_reg     <= pkt_reg;
                  prog_ok_reg   <= 1'b1;
                  modo_prog_reg <= 1'b0;
                  estado_reg    <= OCIOSO;
               end
            end
            BLOQUEADO: begin
               if (bloq_cnt_reg == '0) begin
                  falhas_reg    <= '0;
                  bloqueado_reg <= 1'b0;
                  estado_reg    <= OCIOSO;
               end else begin
                  bloq_cnt_reg <= bloq_cnt_reg - 1'b1;
               end
            end
            default: estado_reg <= OCIOSO;
         endcase
      end
   end

   assign senha_ok   = senha_ok_reg;
   assign senha_erro = senha_erro_reg;
   assign prog_ok    = prog_ok_reg;
   assign modo_prog  = modo_prog_reg;
   assign bloqueado  = bloqueado_reg;
   assign falhas     = 2'(falhas_reg);
endmodule

// File: tb/tb_verificador_de_senha.sv
// Bench for verificador_de_senha: directed transactions with literal checks plus
// a cycle-numbered event model compared against the outputs every cycle.
module tb_verificador_de_senha;
   import verificador_de_senha_pkg::*;

   localparam int MAXT = 3;
   localparam int TBLQ = 40;
   localparam int TPRG = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       digitos_valid = 1'b0;
   senhaPac_t  digitos_value, senha_mestra;
   logic       senha_ok, senha_erro, prog_ok, modo_prog, bloqueado;
   logic [1:0] falhas;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   verificador_de_senha #(
      .MAX_TENTATIVAS(MAXT),
      .T_BLOQUEIO(TBLQ),
      .T_PROG(TPRG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .digitos_value(digitos_value),
      .digitos_valid(digitos_valid),
      .senha_mestra(senha_mestra),
      .senha_ok(senha_ok),
      .senha_erro(senha_erro),
      .prog_ok(prog_ok),
      .modo_prog(modo_prog),
      .bloqueado(bloqueado),
      .falhas(falhas)
   );

   // Builds a packet from keys typed in order; the last key lands in digits[19].
   function automatic senhaPac_t pkt(input int n, input logic [47:0] d);
      senhaPac_t p;
      for (int k = 0; k < 20; k++)
         p[19-k] = (k < n) ? d[4*k +: 4] : 4'hF;
      return p;
   endfunction

   function automatic bit wf(input senhaPac_t p);
      int n = 0;
      int i = 19;
      while (i >= 0 && p[i] != 4'hF) begin
         if (p[i] > 4'd9) return 1'b0;
         n++;
         i--;
      end
      while (i >= 0) begin
         if (p[i] != 4'hF) return 1'b0;
         i--;
      end
      return (n >= 4) && (n <= 12);
   endfunction

   function automatic bit is_be(input senhaPac_t p);
      return (p == {20{4'hB}}) || (p == {20{4'hE}});
   endfunction

   task automatic check(input string nome, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
      end
   endtask

   // Model: every accepted packet is resolved at capture edge + 2; time limits
   // are kept as absolute edge numbers.
   int        e_cnt = 0;
   bit        m_ready = 0, m_ok = 0, m_erro = 0, m_pok = 0, m_prog = 0, m_bloq = 0;
   int        m_falhas = 0, m_bloq_end = 0, m_deadline = 0;
   senhaPac_t m_senha;
   bit        act_valid = 0, act_prog = 0;
   int        act_edge = 0;
   senhaPac_t act_pkt;

   initial begin
      bit avail;
      forever begin
         @(posedge clk);
         e_cnt++;
         m_ok = 0; m_erro = 0; m_pok = 0;
         if (rst) begin
            m_senha = 80'h4321_FFFF_FFFF_FFFF_FFFF;
            m_falhas = 0; m_prog = 0; m_bloq = 0; act_valid = 0;
            m_ready = 1;
         end else begin
            avail = !m_bloq && !act_valid;
            if (act_valid && act_edge == e_cnt) begin
               act_valid = 0;
               if (!act_prog) begin
                  if (act_pkt == senha_mestra && wf(act_pkt)) begin
                     m_prog = 1; m_deadline = e_cnt + TPRG; m_falhas = 0;
                  end else if (act_pkt == m_senha) begin
                     m_ok = 1; m_falhas = 0;
                  end else begin
                     m_erro = 1;
                     if (m_falhas < MAXT) m_falhas++;
                     if (m_falhas == MAXT) begin
                        m_bloq = 1; m_bloq_end = e_cnt + TBLQ;
                     end
                  end
               end else begin
                  if (is_be(act_pkt)) begin
                     m_erro = 1; m_prog = 0;
                  end else if (wf(act_pkt) && act_pkt != senha_mestra) begin
                     m_senha = act_pkt; m_pok = 1; m_prog = 0;
                  end else begin
                     m_erro = 1; m_deadline = e_cnt + TPRG;
                  end
               end
            end else if (m_bloq && e_cnt == m_bloq_end) begin
               m_bloq = 0; m_falhas = 0;
            end else if (avail && digitos_valid && (m_prog || !is_be(digitos_value))) begin
               act_valid = 1; act_edge = e_cnt + 2; act_prog = m_prog; act_pkt = digitos_value;
            end else if (avail && m_prog && e_cnt == m_deadline) begin
               m_prog = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_ready) begin
            check("cmp_senha_ok", int'(senha_ok), int'(m_ok));
            check("cmp_senha_erro", int'(senha_erro), int'(m_erro));
            check("cmp_prog_ok", int'(prog_ok), int'(m_pok));
            check("cmp_modo_prog", int'(modo_prog), int'(m_prog));
            check("cmp_bloqueado", int'(bloqueado), int'(m_bloq));
            check("cmp_falhas", int'(falhas), m_falhas);
         end
      end
   end

   task automatic tx(input string nome, input senhaPac_t p, input bit eok, input bit eerro, input bit epok);
      digitos_valid = 1'b1;
      digitos_value = p;
      @(negedge clk);
      digitos_valid = 1'b0;
      @(negedge clk);
      check({nome, ":early"}, int'({senha_ok, senha_erro, prog_ok}), 0);
      @(negedge clk);
      check({nome, ":pulse"}, int'({senha_ok, senha_erro, prog_ok}), int'({eok, eerro, epok}));
      $display("[TB] tx %-16s ok=%0b erro=%0b prog_ok=%0b falhas=%0d modo_prog=%0b bloqueado=%0b",
               nome, senha_ok, senha_erro, prog_ok, falhas, modo_prog, bloqueado);
   endtask

   initial begin
      senhaPac_t p1234, p9999, pm, p56789, p12, allb, alle;
      int k;
      p1234  = pkt(4, 48'h1234);
      p9999  = pkt(4, 48'h9999);
      pm     = pkt(5, 48'h00000);
      p56789 = pkt(5, 48'h56789);
      p12    = pkt(2, 48'h12);
      allb   = {20{4'hB}};
      alle   = {20{4'hE}};
      senha_mestra  = pm;
      digitos_value = allb;

      repeat (3) @(negedge clk);
      check("rst_pulsos", int'({senha_ok, senha_erro, prog_ok}), 0);
      check("rst_niveis", int'({modo_prog, bloqueado}), 0);
      check("rst_falhas", int'(falhas), 0);

      rst = 1'b0;
      tx("primeiro", p1234, 1, 0, 0);
      check("primeiro_falhas", int'(falhas), 0);
      tx("e_ocioso", alle, 0, 0, 0);
      tx("b_ocioso", allb, 0, 0, 0);
      tx("errada", p9999, 0, 1, 0);
      check("errada_falhas", int'(falhas), 1);
      tx("e_ocioso2", alle, 0, 0, 0);
      check("e_falhas", int'(falhas), 1);

      // second packet arrives while the first is being verified
      digitos_valid = 1'b1; digitos_value = p9999;
      @(negedge clk);
      digitos_value = p1234;
      @(negedge clk);
      digitos_valid = 1'b0;
      check("verif_early", int'({senha_ok, senha_erro}), 0);
      @(negedge clk);
      check("verif_erro", int'({senha_ok, senha_erro}), 1);
      check("verif_falhas", int'(falhas), 2);
      repeat (2) @(negedge clk);
      check("verif_descarta", int'(senha_ok), 0);
      tx("certa", p1234, 1, 0, 0);
      check("certa_falhas", int'(falhas), 0);

      tx("bloq1", p9999, 0, 1, 0);
      tx("bloq2", p9999, 0, 1, 0);
      tx("bloq3", p9999, 0, 1, 0);
      check("bloq_ativo", int'(bloqueado), 1);
      check("bloq_falhas", int'(falhas), 3);
      tx("durante_bloq", p1234, 0, 0, 0);
      k = 3;
      while (bloqueado && k < 3 * TBLQ) begin
         @(negedge clk);
         k++;
      end
      check("bloq_duracao", k, TBLQ);
      check("bloq_fim_falhas", int'(falhas), 0);
      tx("apos_bloq", p1234, 1, 0, 0);

      tx("mestra", pm, 0, 0, 0);
      check("mestra_modo", int'(modo_prog), 1);
      tx("grava", p56789, 0, 0, 1);
      check("grava_modo", int'(modo_prog), 0);
      tx("antiga", p1234, 0, 1, 0);
      tx("nova", p56789, 1, 0, 0);

      tx("mestra_b", pm, 0, 0, 0);
      tx("cancela", allb, 0, 1, 0);
      check("cancela_modo", int'(modo_prog), 0);
      tx("inalterada", p56789, 1, 0, 0);

      tx("mestra_t", pm, 0, 0, 0);
      check("mestra_t_modo", int'(modo_prog), 1);
      k = 0;
      while (modo_prog && k < 3 * TPRG) begin
         @(negedge clk);
         k++;
      end
      check("prog_timeout", k, TPRG);

      tx("mestra_m", pm, 0, 0, 0);
      tx("curta", p12, 0, 1, 0);
      check("curta_modo", int'(modo_prog), 1);
      tx("mestra_em_prog", pm, 0, 1, 0);
      check("mestra_em_prog_modo", int'(modo_prog), 1);
      tx("e_prog", alle, 0, 1, 0);
      check("e_prog_modo", int'(modo_prog), 0);
      tx("ainda_nova", p56789, 1, 0, 0);

      tx("rb1", p9999, 0, 1, 0);
      tx("rb2", p9999, 0, 1, 0);
      tx("rb3", p9999, 0, 1, 0);
      check("rb_bloq", int'(bloqueado), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rb_rst_bloq", int'(bloqueado), 0);
      check("rb_rst_falhas", int'(falhas), 0);
      tx("rb_padrao", p1234, 1, 0, 0);

      tx("rp_mestra", pm, 0, 0, 0);
      check("rp_modo", int'(modo_prog), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rp_rst_modo", int'(modo_prog), 0);
      tx("rp_nova_rejeita", p56789, 0, 1, 0);
      tx("rp_padrao", p1234, 1, 0, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
